// File: rtl/irq_ctrl.sv
// irq_ctrl: fixed-priority interrupt controller with a 4-word register window.
// Build option: define IRQ_CTRL_EDGE_EN to add edge latches, the EDGE register
// and STATUS write-1-to-clear. Without it every source is level sensitive.
module irq_ctrl #(
    parameter int unsigned NSRC = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic            cs,
    input  logic [1:0]      addr,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    output logic [31:0]     rdata,
    output logic            irq,
    output logic [29:0]     ivector
);

    logic [NSRC-1:0] s1;
    logic [NSRC-1:0] s2;
    logic [NSRC-1:0] enable_q;
    logic [24:0]     vbase_q;    // VBASE[31:7]
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] active;
    logic [2:0]      id;
    logic            found;

    // Two-flop synchronizer for the asynchronous source lines
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= src;
            s2 <= s1;
        end
    end

    // ENABLE and VBASE registers, byte-lane gated writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_q <= '0;
            vbase_q  <= '0;
        end else if (cs) begin
            if (addr == 2'd0 && wstrb[0])
                enable_q <= wdata[NSRC-1:0];
            if (addr == 2'd2) begin
                if (wstrb[0]) vbase_q[0]     <= wdata[7];
                if (wstrb[1]) vbase_q[8:1]   <= wdata[15:8];
                if (wstrb[2]) vbase_q[16:9]  <= wdata[23:16];
                if (wstrb[3]) vbase_q[24:17] <= wdata[31:24];
            end
        end
    end

`ifdef IRQ_CTRL_EDGE_EN
    logic [NSRC-1:0] s3;
    logic [NSRC-1:0] edge_q;
    logic [NSRC-1:0] edge_nxt;
    logic [NSRC-1:0] latch_q;
    logic [NSRC-1:0] w1c;

    // Next EDGE value and W1C mask seen by the latches at this edge
    always_comb begin
        edge_nxt = edge_q;
        w1c      = '0;
        if (cs && wstrb[0]) begin
            if (addr == 2'd3) edge_nxt = wdata[NSRC-1:0];
            if (addr == 2'd1) w1c      = wdata[NSRC-1:0];
        end
    end

    // Edge latches: a new rise wins over a same-edge clear; leaving edge mode clears
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s3      <= '0;
            edge_q  <= '0;
            latch_q <= '0;
        end else begin
            s3      <= s2;
            edge_q  <= edge_nxt;
            latch_q <= edge_nxt & ((latch_q & ~w1c) | (s2 & ~s3));
        end
    end

    // Pending: latched in edge mode, synchronized level otherwise
    always_comb begin
        pending = latch_q | (~edge_q & s2);
    end
`else
    // Pending follows the synchronized level on every source
    always_comb begin
        pending = s2;
    end
`endif

    // Masking and fixed priority, lowest index wins
    always_comb begin
        active = pending & enable_q;
        id     = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (active[i] && !found) begin
                id    = 3'(i);
                found = 1'b1;
            end
        end
    end

    // Registered request and vector; vector holds while nothing is active
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq     <= 1'b0;
            ivector <= '0;
        end else begin
            irq <= |active;
            if (|active)
                ivector <= {vbase_q, id, 2'b00};
        end
    end

    // Combinational read mux, zero outside the window and on unused bits
    always_comb begin
        rdata = '0;
        if (cs) begin
            case (addr)
                2'd0: rdata[NSRC-1:0] = enable_q;
                2'd1: begin
                    rdata[NSRC-1:0] = pending;
                    rdata[10:8]     = id;
                    rdata[11]       = irq;
                end
                2'd2: rdata[31:7] = vbase_q;
`ifdef IRQ_CTRL_EDGE_EN
                2'd3: rdata[NSRC-1:0] = edge_q;
`endif
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: table-driven vectors plus hand-written multi-cycle sequences for irq_ctrl.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  src;
    logic        cs;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        irq;
    logic [29:0] ivector;

    int tests = 0;
    int fails = 0;

    irq_ctrl #(.NSRC(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .src     (src),
        .cs      (cs),
        .addr    (addr),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .rdata   (rdata),
        .irq     (irq),
        .ivector (ivector)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  en;
        logic [7:0]  src;
        logic        exp_irq;
        logic [29:0] exp_ivec;
        logic [31:0] exp_status;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        cs = 1'b1; addr = a; wdata = d; wstrb = s;
        @(posedge clk);
        #1;
        cs = 1'b0; wstrb = 4'h0; wdata = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        cs = 1'b1; addr = a;
        #1;
        d = rdata;
        cs = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;

        vecs[0] = '{8'h05, 8'h04, 1'b1, 30'h408, 32'h0000_0A04};
        vecs[1] = '{8'h05, 8'h05, 1'b1, 30'h400, 32'h0000_0805};
        vecs[2] = '{8'h00, 8'hFF, 1'b0, 30'h400, 32'h0000_00FF};
        vecs[3] = '{8'h80, 8'hFF, 1'b1, 30'h41C, 32'h0000_0FFF};
        vecs[4] = '{8'h30, 8'h60, 1'b1, 30'h414, 32'h0000_0D60};
        vecs[5] = '{8'hFF, 8'h00, 1'b0, 30'h414, 32'h0000_0000};
        vecs[6] = '{8'h0A, 8'h08, 1'b1, 30'h40C, 32'h0000_0B08};

        reset = 1'b0; src = '0; cs = 1'b0; addr = '0; wdata = '0; wstrb = '0;

        // Reset state
        #12;
        check("reset_irq", {31'b0, irq}, 32'h0);
        check("reset_ivec", {2'b0, ivector}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), d);
            check("reset_read", d, 32'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        tick(1);

        // Level latency: rise seen after E2, fall seen after E2
        wr(2'd2, 32'h0000_1000, 4'hF);
        wr(2'd0, 32'h0000_0001, 4'h1);
        src = 8'h01;
        tick(1); check("lvl_rise_e0", {31'b0, irq}, 32'h0);
        tick(1); check("lvl_rise_e1", {31'b0, irq}, 32'h0);
        tick(1); check("lvl_rise_e2", {31'b0, irq}, 32'h1);
        check("lvl_ivec", {2'b0, ivector}, 32'h400);
        src = 8'h00;
        tick(2); check("lvl_fall_e1", {31'b0, irq}, 32'h1);
        tick(1); check("lvl_fall_e2", {31'b0, irq}, 32'h0);
        check("lvl_ivec_hold", {2'b0, ivector}, 32'h400);

        // Table of enable/source patterns
        for (int i = 0; i < 7; i++) begin
            wr(2'd0, {24'h0, vecs[i].en}, 4'h1);
            src = vecs[i].src;
            tick(3);
            check("vec_irq", {31'b0, irq}, {31'b0, vecs[i].exp_irq});
            check("vec_ivec", {2'b0, ivector}, {2'b0, vecs[i].exp_ivec});
            rd(2'd1, d);
            check("vec_status", d, vecs[i].exp_status);
        end

        // Clearing ENABLE drops irq one edge later, pending retained
        wr(2'd0, 32'h0, 4'h1);
        check("dis_irq_same", {31'b0, irq}, 32'h1);
        tick(1);
        check("dis_irq_next", {31'b0, irq}, 32'h0);
        rd(2'd1, d);
        check("dis_status", d, 32'h0000_0008);

        // Read data is zero without chip select
        cs = 1'b0; addr = 2'd1;
        #1;
        check("rdata_no_cs", rdata, 32'h0);

        // VBASE field width and byte lanes, ENABLE strobe gating
        wr(2'd2, 32'hFFFF_FFFF, 4'hF);
        rd(2'd2, d); check("vbase_full", d, 32'hFFFF_FF80);
        wr(2'd2, 32'h1234_5678, 4'h2);
        rd(2'd2, d); check("vbase_lane1", d, 32'hFFFF_5680);
        wr(2'd0, 32'h0000_00FF, 4'h0);
        rd(2'd0, d); check("enable_nostrb", d, 32'h0);
        wr(2'd2, 32'h0000_1000, 4'hF);
        src = 8'h00;
        tick(3);

`ifdef IRQ_CTRL_EDGE_EN
        // Edge latch: short pulse latched, irq after E3, W1C drops it next edge
        wr(2'd3, 32'h02, 4'h1);
        wr(2'd0, 32'h02, 4'h1);
        rd(2'd3, d); check("edge_reg", d, 32'h02);
        src = 8'h02; tick(1); src = 8'h00;
        tick(1); check("edge_e1", {31'b0, irq}, 32'h0);
        tick(1); check("edge_e2", {31'b0, irq}, 32'h0);
        tick(1); check("edge_e3", {31'b0, irq}, 32'h1);
        check("edge_ivec", {2'b0, ivector}, 32'h404);
        tick(4); check("edge_held", {31'b0, irq}, 32'h1);
        rd(2'd1, d); check("edge_status", d, 32'h0000_0902);
        wr(2'd1, 32'h02, 4'h1);
        check("w1c_same", {31'b0, irq}, 32'h1);
        tick(1); check("w1c_next", {31'b0, irq}, 32'h0);
        rd(2'd1, d); check("w1c_status", d, 32'h0);

        // Collision: W1C on the edge where a new rise is detected
        src = 8'h02; tick(1); src = 8'h00;
        tick(5); check("coll_pre", {31'b0, irq}, 32'h1);
        src = 8'h02;
        tick(2);
        wr(2'd1, 32'h02, 4'h1);
        tick(1); check("coll_irq", {31'b0, irq}, 32'h1);
        rd(2'd1, d); check("coll_status", d, 32'h0000_0902);
        src = 8'h00;
        tick(3);
        wr(2'd1, 32'h02, 4'h1);
        tick(1); check("coll_clear", {31'b0, irq}, 32'h0);

        // Leaving edge mode clears the latch
        src = 8'h02; tick(1); src = 8'h00;
        tick(5); check("e2l_pre", {31'b0, irq}, 32'h1);
        wr(2'd3, 32'h00, 4'h1);
        tick(2); check("e2l_irq", {31'b0, irq}, 32'h0);
        rd(2'd1, d); check("e2l_status", d, 32'h0);
        wr(2'd3, 32'h02, 4'h1);
        tick(2); check("e2l_relatch", {31'b0, irq}, 32'h0);
        wr(2'd3, 32'h00, 4'h1);
`else
        // Level-only build: EDGE window and STATUS writes are inert
        wr(2'd3, 32'hFF, 4'hF);
        rd(2'd3, d); check("edge_off_read", d, 32'h0);
        wr(2'd0, 32'h02, 4'h1);
        src = 8'h02; tick(1); src = 8'h00;
        tick(1); check("pulse_e1", {31'b0, irq}, 32'h0);
        tick(1); check("pulse_e2", {31'b0, irq}, 32'h1);
        tick(1); check("pulse_e3", {31'b0, irq}, 32'h0);
        wr(2'd1, 32'hFF, 4'hF);
        tick(3); check("pulse_after", {31'b0, irq}, 32'h0);
        rd(2'd1, d); check("pulse_status", d, 32'h0);
`endif

        // Asynchronous reset while an interrupt is up
        wr(2'd0, 32'h02, 4'h1);
        src = 8'h02;
        tick(3); check("pre_reset_irq", {31'b0, irq}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_irq", {31'b0, irq}, 32'h0);
        check("async_rst_ivec", {2'b0, ivector}, 32'h0);
        src = 8'h00;
        @(negedge clk);
        reset = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), d);
            check("post_rst_read", d, 32'h0);
        end
        check("post_rst_irq", {31'b0, irq}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
